// File: rtl/dl_set_bit_iter.sv
// Iterative set-bit scanner: accepts a mask and emits the index and one-hot of
// each set bit, lowest index first, one per output handshake.
module dl_set_bit_iter #(
  parameter int NUM_BITS = 8,
  localparam int IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] in_vec,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDX_W-1:0]    out_idx,
  output logic [NUM_BITS-1:0] out_onehot,
  output logic                out_last,
  input  logic                abort,
  output logic                busy
);

  // state | meaning
  // IDLE  | waiting for a mask; in_ready high unless abort or rst
  // ITER  | presenting the lowest remaining set bit on the output port
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ITER = 1'b1;

  logic [0:0]          state;
  logic [NUM_BITS-1:0] remaining;
  logic [NUM_BITS-1:0] lowest;
  logic [NUM_BITS-1:0] rest;
  logic [IDX_W-1:0]    enc;
  logic                iter;
  logic                last_bit;

  assign iter     = (state == ITER);
  assign lowest   = remaining & (~remaining + NUM_BITS'(1));
  assign rest     = remaining & (remaining - NUM_BITS'(1));
  assign last_bit = (rest == '0);

  always_comb begin
    enc = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      if (lowest[i]) enc = enc | IDX_W'(i);
    end
  end

  // rst is folded in so in_ready reads low for the whole reset window
  assign in_ready   = !iter && !abort && !rst;
  assign out_valid  = iter;
  assign busy       = iter;
  assign out_onehot = iter ? lowest : '0;
  assign out_idx    = iter ? enc : '0;
  assign out_last   = iter && last_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
    end else if (abort) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          // an all-zero mask is consumed without producing any output
          if (in_valid && (in_vec != '0)) begin
            remaining <= in_vec;
            state     <= ITER;
          end
        end
        ITER: begin
          if (out_ready) begin
            if (last_bit) begin
              remaining <= '0;
              state     <= IDLE;
            end else begin
              remaining <= remaining & ~lowest;
            end
          end
        end
        default: begin
          state     <= IDLE;
          remaining <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dl_set_bit_iter.sv
// Directed bench for dl_set_bit_iter: table-driven masks on an 8-bit build plus
// hand sequences for stall, abort, async reset and the 1/64-bit builds.
module tb_dl_set_bit_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, out_valid, out_ready, out_last, abort, busy;
  logic [7:0] in_vec, out_onehot;
  logic [2:0] out_idx;

  logic       v1_in_valid, v1_in_ready, v1_in_vec, v1_out_valid, v1_out_idx;
  logic       v1_out_onehot, v1_out_last, v1_busy;

  logic        w_in_valid, w_in_ready, w_out_valid, w_out_last, w_busy;
  logic [63:0] w_in_vec, w_out_onehot;
  logic [5:0]  w_out_idx;

  dl_set_bit_iter #(.NUM_BITS(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_onehot(out_onehot), .out_last(out_last), .abort(abort), .busy(busy));

  dl_set_bit_iter #(.NUM_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1_in_valid), .in_ready(v1_in_ready), .in_vec(v1_in_vec),
    .out_valid(v1_out_valid), .out_ready(1'b1), .out_idx(v1_out_idx),
    .out_onehot(v1_out_onehot), .out_last(v1_out_last), .abort(1'b0), .busy(v1_busy));

  dl_set_bit_iter #(.NUM_BITS(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_vec(w_in_vec),
    .out_valid(w_out_valid), .out_ready(1'b1), .out_idx(w_out_idx),
    .out_onehot(w_out_onehot), .out_last(w_out_last), .abort(1'b0), .busy(w_busy));

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0]  vec;
    int          n;
    logic [23:0] idxs;   // k-th expected index in idxs[3k +: 3]
  } vec_t;

  vec_t tbl [6];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] ei;
    int k, hs, cyc;

    tbl[0] = '{vec: 8'hA4, n: 3, idxs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd5, 3'd2}};
    tbl[1] = '{vec: 8'h01, n: 1, idxs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
    tbl[2] = '{vec: 8'h80, n: 1, idxs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7}};
    tbl[3] = '{vec: 8'h00, n: 0, idxs: 24'd0};
    tbl[4] = '{vec: 8'h18, n: 2, idxs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd3}};
    tbl[5] = '{vec: 8'h55, n: 4, idxs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd4, 3'd2, 3'd0}};

    in_valid = 0; in_vec = 0; out_ready = 1; abort = 0;
    v1_in_valid = 0; v1_in_vec = 0; w_in_valid = 0; w_in_vec = 0;

    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_onehot", out_onehot, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); rst = 0;
    @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      chk($sformatf("v%0d_in_ready_pre", t), in_ready, 1);
      in_valid = 1; in_vec = tbl[t].vec;
      @(posedge clk); @(negedge clk);
      in_valid = 0;
      for (int j = 0; j < tbl[t].n; j++) begin
        ei = tbl[t].idxs[3*j +: 3];
        chk($sformatf("v%0d_%0d_valid", t, j), out_valid, 1);
        chk($sformatf("v%0d_%0d_busy", t, j), busy, 1);
        chk($sformatf("v%0d_%0d_in_ready", t, j), in_ready, 0);
        chk($sformatf("v%0d_%0d_idx", t, j), out_idx, ei);
        chk($sformatf("v%0d_%0d_onehot", t, j), out_onehot, 8'h01 << ei);
        chk($sformatf("v%0d_%0d_last", t, j), out_last, (j == tbl[t].n - 1));
        @(posedge clk); @(negedge clk);
      end
      chk($sformatf("v%0d_post_valid", t), out_valid, 0);
      chk($sformatf("v%0d_post_busy", t), busy, 0);
      chk($sformatf("v%0d_post_in_ready", t), in_ready, 1);
    end

    // all ones with out_ready pattern 1,0,0 repeating
    in_valid = 1; in_vec = 8'hFF;
    @(posedge clk); @(negedge clk);
    in_valid = 0;
    k = 0; hs = 0; cyc = 0;
    while (k < 8 && cyc < 40) begin
      out_ready = (cyc % 3 == 0);
      chk($sformatf("ff_c%0d_valid", cyc), out_valid, 1);
      chk($sformatf("ff_c%0d_idx", cyc), out_idx, k[2:0]);
      chk($sformatf("ff_c%0d_onehot", cyc), out_onehot, 8'h01 << k);
      chk($sformatf("ff_c%0d_last", cyc), out_last, (k == 7));
      @(posedge clk);
      if (out_ready) begin k++; hs++; end
      @(negedge clk);
      cyc++;
    end
    chk("ff_handshakes", hs, 8);
    out_ready = 1;
    chk("ff_post_valid", out_valid, 0);
    chk("ff_post_in_ready", in_ready, 1);

    // abort on the first handshake of 0x81
    in_valid = 1; in_vec = 8'h81;
    @(posedge clk); @(negedge clk);
    in_valid = 0;
    chk("ab_idx0", out_idx, 0);
    chk("ab_valid0", out_valid, 1);
    abort = 1;
    chk("ab_in_ready_iter", in_ready, 0);
    @(posedge clk); @(negedge clk);
    abort = 0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("ab_idle_valid%0d", c), out_valid, 0);
      chk($sformatf("ab_idle_busy%0d", c), busy, 0);
      @(posedge clk); @(negedge clk);
    end
    chk("ab_in_ready_after", in_ready, 1);

    // abort in IDLE blocks acceptance
    abort = 1; in_valid = 1; in_vec = 8'h10;
    #1;
    chk("ab_idle_in_ready", in_ready, 0);
    @(posedge clk); @(negedge clk);
    abort = 0; in_valid = 0;
    chk("ab_noaccept_valid", out_valid, 0);
    chk("ab_noaccept_busy", busy, 0);

    // async reset mid-iteration
    in_valid = 1; in_vec = 8'h0F;
    @(posedge clk); @(negedge clk);
    in_valid = 0;
    chk("rs_idx0", out_idx, 0);
    @(posedge clk); #2;
    chk("rs_idx1", out_idx, 1);
    rst = 1;
    #1;
    chk("rs_valid", out_valid, 0);
    chk("rs_idx", out_idx, 0);
    chk("rs_onehot", out_onehot, 0);
    chk("rs_busy", busy, 0);
    chk("rs_in_ready", in_ready, 0);
    @(negedge clk); rst = 0;
    @(negedge clk);
    in_valid = 1; in_vec = 8'h10;
    @(posedge clk); @(negedge clk);
    in_valid = 0;
    chk("rs_new_valid", out_valid, 1);
    chk("rs_new_idx", out_idx, 4);
    chk("rs_new_onehot", out_onehot, 8'h10);
    chk("rs_new_last", out_last, 1);
    @(posedge clk); @(negedge clk);
    chk("rs_new_done", out_valid, 0);

    // NUM_BITS=1 and NUM_BITS=64 builds
    v1_in_valid = 1; v1_in_vec = 1'b1;
    w_in_valid = 1; w_in_vec = 64'h8000_0000_0000_0000;
    @(posedge clk); @(negedge clk);
    v1_in_valid = 0; w_in_valid = 0;
    chk("n1_valid", v1_out_valid, 1);
    chk("n1_idx", v1_out_idx, 0);
    chk("n1_onehot", v1_out_onehot, 1);
    chk("n1_last", v1_out_last, 1);
    chk("n64_valid", w_out_valid, 1);
    chk("n64_idx", w_out_idx, 63);
    chk("n64_onehot", w_out_onehot, 64'h8000_0000_0000_0000);
    chk("n64_last", w_out_last, 1);
    @(posedge clk); @(negedge clk);
    chk("n1_done", v1_out_valid, 0);
    chk("n1_busy", v1_busy, 0);
    chk("n1_in_ready", v1_in_ready, 1);
    chk("n64_done", w_out_valid, 0);
    chk("n64_busy", w_busy, 0);
    chk("n64_in_ready", w_in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
